// File: rtl/wr_resp_scheduler.sv
// Write-response scheduler: round-robin arbitration of completion sources into
// per-direction in-order response FIFOs; non-writes are accepted and dropped.
`ifndef CMD_WRITE
`define CMD_WRITE 4'h2
`endif

package vector_cache_pkg;
  typedef struct packed {
    logic [2:0] direction_id;
    logic [7:0] tag;
  } txnid_t;

  typedef struct packed {
    logic [3:0] cmd_opcode;
    txnid_t     cmd_txnid;
    logic [7:0] cmd_sideband;
  } input_req_pld_t;

  typedef struct packed {
    txnid_t     txnid;
    logic [7:0] sideband;
  } wr_resp_pld_t;
endpackage

module wr_resp_scheduler
  import vector_cache_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NSRC  = 2,
  parameter int DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NSRC-1:0]                          v_src_vld,
  input  input_req_pld_t [NSRC-1:0]                v_src_pld,
  output logic [NSRC-1:0]                          v_src_rdy,
  output logic [WIDTH-1:0]                         v_wresp_vld,
  output wr_resp_pld_t [WIDTH-1:0]                 v_wresp_pld,
  input  logic [WIDTH-1:0]                         v_wresp_rdy,
  output logic [WIDTH-1:0][$clog2(DEPTH+1)-1:0]    v_fifo_cnt,
  output logic                                     busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [CW-1:0]  cnt_r    [WIDTH];
  logic [PW-1:0]  wr_ptr_r [WIDTH];
  logic [PW-1:0]  rd_ptr_r [WIDTH];
  wr_resp_pld_t   mem_r    [WIDTH][DEPTH];
  logic [SW-1:0]  rr_ptr_r;

  logic [WIDTH-1:0] full_s;
  logic [NSRC-1:0]  is_wr_s;
  logic [NSRC-1:0]  dir_full_s;
  logic [NSRC-1:0]  elig_s;
  logic [NSRC-1:0]  gnt_s;
  logic             gnt_any_s;
  logic [SW-1:0]    gnt_idx_s;
  logic [SW-1:0]    rr_nxt_s;
  logic [WIDTH-1:0] push_s;
  logic [WIDTH-1:0] pop_s;
  wr_resp_pld_t     push_pld_s;

  // Full flags come from the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    full_s = '0;
    for (int d = 0; d < WIDTH; d++) begin
      full_s[d] = (cnt_r[d] == CW'(DEPTH));
    end
  end

  // Classify each source; out-of-range directions behave like non-writes.
  always_comb begin
    is_wr_s    = '0;
    dir_full_s = '0;
    elig_s     = '0;
    for (int s = 0; s < NSRC; s++) begin
      is_wr_s[s] = (v_src_pld[s].cmd_opcode == `CMD_WRITE) &&
                   (int'(v_src_pld[s].cmd_txnid.direction_id) < WIDTH);
      for (int d = 0; d < WIDTH; d++) begin
        dir_full_s[s] = dir_full_s[s] |
                        ((int'(v_src_pld[s].cmd_txnid.direction_id) == d) && full_s[d]);
      end
      elig_s[s] = v_src_vld[s] && !(is_wr_s[s] && dir_full_s[s]);
    end
  end

  // Round-robin pick: first eligible source at or after rr_ptr_r.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (!gnt_any_s && elig_s[s] && (((int'(rr_ptr_r) + k) % NSRC) == s)) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = SW'(s);
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end
    if (gnt_any_s) begin
      rr_nxt_s = SW'((int'(gnt_idx_s) + 1) % NSRC);
    end else begin
      rr_nxt_s = rr_ptr_r;
    end
  end

  // Decode the grant into the handshake, the FIFO push strobes and the push payload.
  always_comb begin
    gnt_s      = '0;
    push_s     = '0;
    push_pld_s = '0;
    for (int s = 0; s < NSRC; s++) begin
      gnt_s[s] = gnt_any_s && (int'(gnt_idx_s) == s);
      if (gnt_s[s]) begin
        push_pld_s.txnid    = v_src_pld[s].cmd_txnid;
        push_pld_s.sideband = v_src_pld[s].cmd_sideband;
      end else begin
        push_pld_s = push_pld_s;
      end
      for (int d = 0; d < WIDTH; d++) begin
        push_s[d] = push_s[d] |
                    (gnt_s[s] && is_wr_s[s] &&
                     (int'(v_src_pld[s].cmd_txnid.direction_id) == d));
      end
    end
    for (int d = 0; d < WIDTH; d++) begin
      pop_s[d] = (cnt_r[d] != CW'(0)) && v_wresp_rdy[d];
    end
    v_src_rdy = gnt_s & {NSRC{rst_n}};
  end

  // Pointer, count and arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
      for (int d = 0; d < WIDTH; d++) begin
        cnt_r[d]    <= '0;
        wr_ptr_r[d] <= '0;
        rd_ptr_r[d] <= '0;
      end
    end else begin
      rr_ptr_r <= rr_nxt_s;
      for (int d = 0; d < WIDTH; d++) begin
        if (push_s[d]) wr_ptr_r[d] <= wr_ptr_r[d] + PW'(1);
        if (pop_s[d])  rd_ptr_r[d] <= rd_ptr_r[d] + PW'(1);
        case ({push_s[d], pop_s[d]})
          2'b10:   cnt_r[d] <= cnt_r[d] + CW'(1);
          2'b01:   cnt_r[d] <= cnt_r[d] - CW'(1);
          default: cnt_r[d] <= cnt_r[d];
        endcase
      end
    end
  end

  // FIFO storage is deliberately not reset; valid gates its visibility.
  always_ff @(posedge clk) begin
    for (int d = 0; d < WIDTH; d++) begin
      if (push_s[d]) mem_r[d][wr_ptr_r[d]] <= push_pld_s;
    end
  end

  // Response outputs are driven straight from registered state.
  always_comb begin
    for (int d = 0; d < WIDTH; d++) begin
      v_wresp_vld[d] = (cnt_r[d] != CW'(0));
      v_wresp_pld[d] = mem_r[d][rd_ptr_r[d]];
      v_fifo_cnt[d]  = cnt_r[d];
    end
    busy = |v_wresp_vld;
  end

endmodule

// File: tb/tb_wr_resp_scheduler.sv
// Self-checking bench for wr_resp_scheduler: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_wr_resp_scheduler;
  import vector_cache_pkg::*;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam logic [3:0] OP_WR = 4'h2;
  localparam logic [3:0] OP_RD = 4'h5;

  logic                      clk;
  logic                      rst_n;
  logic [N-1:0]              src_vld;
  input_req_pld_t [N-1:0]    src_pld;
  logic [N-1:0]              src_rdy;
  logic [W-1:0]              wresp_vld;
  wr_resp_pld_t [W-1:0]      wresp_pld;
  logic [W-1:0]              wresp_rdy;
  logic [W-1:0][CW-1:0]      fifo_cnt;
  logic                      busy;

  wr_resp_scheduler #(.WIDTH(W), .NSRC(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .v_src_vld(src_vld), .v_src_pld(src_pld), .v_src_rdy(src_rdy),
    .v_wresp_vld(wresp_vld), .v_wresp_pld(wresp_pld), .v_wresp_rdy(wresp_rdy),
    .v_fifo_cnt(fifo_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_resp_pld_t mq [W][$];
  int           gnt_log [$];
  int           m_rr;
  int           exp_gnt;
  int           checks;
  int           failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic input_req_pld_t mk(input logic [3:0] op, input logic [2:0] dir,
                                        input logic [7:0] tag, input logic [7:0] sb);
    input_req_pld_t p;
    p.cmd_opcode             = op;
    p.cmd_txnid.direction_id = dir;
    p.cmd_txnid.tag          = tag;
    p.cmd_sideband           = sb;
    return p;
  endfunction

  function automatic bit is_write(input input_req_pld_t p);
    return (p.cmd_opcode == OP_WR) && (int'(p.cmd_txnid.direction_id) < W);
  endfunction

  // Reference arbitration: scan from the round-robin pointer for the first
  // valid source whose write target still has room (or that is not a write).
  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      int s = (m_rr + i) % N;
      if (src_vld[s]) begin
        if (!is_write(src_pld[s]) ||
            mq[int'(src_pld[s].cmd_txnid.direction_id)].size() < D) return s;
      end
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] er;
    logic [W-1:0] ev;
    exp_gnt = model_grant();
    er = '0;
    if (exp_gnt >= 0) er[exp_gnt] = 1'b1;
    chk("src_rdy", 32'(src_rdy), 32'(er));
    for (int d = 0; d < W; d++) begin
      ev[d] = (mq[d].size() != 0);
      chk($sformatf("fifo_cnt%0d", d), 32'(fifo_cnt[d]), 32'(mq[d].size()));
      if (ev[d]) chk($sformatf("wresp_pld%0d", d), 32'(wresp_pld[d]), 32'(mq[d][0]));
    end
    chk("wresp_vld", 32'(wresp_vld), 32'(ev));
    chk("busy", 32'(busy), 32'(|ev));
  endtask

  task automatic model_update();
    logic [W-1:0] pops;
    wr_resp_pld_t e;
    for (int d = 0; d < W; d++) pops[d] = (mq[d].size() != 0) && wresp_rdy[d];
    for (int d = 0; d < W; d++) if (pops[d]) void'(mq[d].pop_front());
    if (exp_gnt >= 0) begin
      gnt_log.push_back(exp_gnt);
      if (is_write(src_pld[exp_gnt])) begin
        e.txnid    = src_pld[exp_gnt].cmd_txnid;
        e.sideband = src_pld[exp_gnt].cmd_sideband;
        mq[int'(src_pld[exp_gnt].cmd_txnid.direction_id)].push_back(e);
      end
      m_rr = (exp_gnt + 1) % N;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic hard_reset();
    #2;
    src_pld[0] = mk(OP_WR, 3'd0, 8'hEE, 8'h00);
    src_pld[1] = mk(OP_RD, 3'd1, 8'hEF, 8'h00);
    src_vld    = '1;
    rst_n      = 1'b0;
    #1;
    for (int d = 0; d < W; d++) mq[d].delete();
    m_rr = 0;
    chk("rst_vld", 32'(wresp_vld), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cnt", 32'(fifo_cnt), 32'(0));
    chk("rst_rdy", 32'(src_rdy), 32'(0));
    src_vld = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int budget;
    int n0;
    logic [3:0] opc;
    logic [2:0] dir;
    int rdy_pct;

    checks = 0; failures = 0; m_rr = 0; exp_gnt = -1;
    rst_n = 1'b0; src_vld = '0; src_pld = '0; wresp_rdy = '1;
    hard_reset();

    // Single write to direction 2 appears one cycle later, then drains.
    src_pld[0] = mk(OP_WR, 3'd2, 8'h16, 8'hA5);
    src_vld = 2'b01;
    n0 = gnt_log.size();
    tick();
    src_vld = 2'b00;
    chk("t035_acc", 32'(gnt_log.size() - n0), 32'(1));
    chk("t035_vld", 32'(wresp_vld), 32'(4'b0100));
    chk("t035_txn", 32'(wresp_pld[2].txnid.tag), 32'(8'h16));
    tick();
    chk("t035_busy", 32'(busy), 32'(0));

    // Two always-valid sources alternate starting from src0 after reset.
    hard_reset();
    gnt_log.delete();
    src_vld = 2'b11;
    for (int i = 0; i < 8; i++) begin
      src_pld[0] = mk(OP_WR, 3'd0, 8'(8'h60 + i), 8'(i));
      src_pld[1] = mk(OP_WR, 3'd1, 8'(8'h70 + i), 8'(i + 16));
      tick();
    end
    src_vld = 2'b00;
    chk("t036_n", 32'(gnt_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      chk($sformatf("t036_gnt%0d", i), 32'(gnt_log[i]), 32'(i % 2));
    repeat (2) tick();

    // Stalled direction 3 accepts four, holds the fifth.
    wresp_rdy = 4'b0111;
    gnt_log.delete();
    k = 0; budget = 0;
    src_pld[0] = mk(OP_WR, 3'd3, 8'h30, 8'h80);
    src_vld = 2'b01;
    while (k < 4 && budget < 20) begin
      tick();
      budget++;
      if (gnt_log.size() > k) begin
        k++;
        src_pld[0] = mk(OP_WR, 3'd3, 8'(8'h30 + k), 8'(8'h80 + k));
      end
    end
    chk("t037_acc4", 32'(k), 32'(4));
    tick(); tick();
    chk("t037_held", 32'(src_rdy), 32'(0));
    chk("t037_cnt3", 32'(fifo_cnt[3]), 32'(4));

    // Other direction, a non-write and an out-of-range direction all pass a full FIFO.
    src_vld = 2'b11;
    src_pld[1] = mk(OP_WR, 3'd1, 8'h41, 8'h11);
    n0 = gnt_log.size(); tick();
    chk("t038_wr1", 32'((gnt_log.size() == n0 + 1) ? gnt_log[$] : -1), 32'(1));
    src_pld[1] = mk(OP_RD, 3'd1, 8'h42, 8'h12);
    n0 = gnt_log.size(); tick();
    chk("t038_nonwr", 32'((gnt_log.size() == n0 + 1) ? gnt_log[$] : -1), 32'(1));
    src_pld[1] = mk(OP_WR, 3'd6, 8'h43, 8'h13);
    n0 = gnt_log.size(); tick();
    chk("t038_oor", 32'((gnt_log.size() == n0 + 1) ? gnt_log[$] : -1), 32'(1));
    src_vld = 2'b01;
    tick();
    chk("t038_noresp", 32'(wresp_vld[1]), 32'(0));
    chk("t038_cnt3", 32'(fifo_cnt[3]), 32'(4));
    wresp_rdy = '1;
    n0 = gnt_log.size(); budget = 0;
    while (gnt_log.size() == n0 && budget < 20) begin
      tick();
      budget++;
    end
    chk("t037_fifth", 32'(gnt_log.size() - n0), 32'(1));
    src_vld = 2'b00;
    repeat (5) tick();

    // Push and pop together at count 2 leaves the count at 2.
    wresp_rdy = 4'b1110;
    src_vld = 2'b01;
    src_pld[0] = mk(OP_WR, 3'd0, 8'h90, 8'h01); tick();
    src_pld[0] = mk(OP_WR, 3'd0, 8'h91, 8'h02); tick();
    chk("t039_cnt2a", 32'(fifo_cnt[0]), 32'(2));
    wresp_rdy = '1;
    src_pld[0] = mk(OP_WR, 3'd0, 8'h92, 8'h03); tick();
    chk("t039_cnt2b", 32'(fifo_cnt[0]), 32'(2));
    src_vld = 2'b00;
    repeat (4) tick();

    // Random traffic: a congested phase followed by a draining phase.
    for (int c = 0; c < 400; c++) begin
      rdy_pct = (c < 200) ? 15 : 65;
      for (int s = 0; s < N; s++) begin
        src_vld[s] = ($urandom_range(0, 9) < 7);
        opc = ($urandom_range(0, 3) != 0) ? OP_WR : 4'($urandom_range(0, 15));
        dir = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        src_pld[s] = mk(opc, dir, 8'($urandom), 8'($urandom));
      end
      for (int d = 0; d < W; d++) wresp_rdy[d] = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end
    src_vld = 2'b00;
    wresp_rdy = '1;
    repeat (6) tick();

    // Reset with three responses queued discards them.
    wresp_rdy = '0;
    src_vld = 2'b01;
    for (int i = 0; i < 3; i++) begin
      src_pld[0] = mk(OP_WR, 3'd2, 8'(8'hC0 + i), 8'(i));
      tick();
    end
    src_vld = 2'b00;
    chk("t040_cnt3", 32'(fifo_cnt[2]), 32'(3));
    hard_reset();
    wresp_rdy = '1;
    repeat (6) begin
      tick();
      chk("t040_stale", 32'(wresp_vld), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wr_resp_scheduler.md
WR_RESP_SCHEDULER -- requirements
Module: wr_resp_scheduler

Interface
REQ-001 SHALL import vector_cache_pkg::*; input payload type input_req_pld_t, output payload type wr_resp_pld_t.
REQ-002 SHALL have parameter WIDTH, default 4, number of response directions.
REQ-003 SHALL have parameter NSRC, default 2, number of completion sources.
REQ-004 SHALL have parameter DEPTH, default 4, entries per direction FIFO (power of two, >=2).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port v_src_vld  input  NSRC  per-source completion valid.
REQ-008 SHALL have port v_src_pld  input  input_req_pld_t[NSRC]  completion payload (cmd_opcode, cmd_txnid, cmd_sideband).
REQ-009 SHALL have port v_src_rdy  output  NSRC  per-source accept.
REQ-010 SHALL have port v_wresp_vld  output  WIDTH  per-direction response valid.
REQ-011 SHALL have port v_wresp_pld  output  wr_resp_pld_t[WIDTH]  per-direction response (txnid, sideband).
REQ-012 SHALL have port v_wresp_rdy  input  WIDTH  per-direction response ready.
REQ-013 SHALL have port v_fifo_cnt  output  WIDTH x $clog2(DEPTH+1)  per-direction occupancy.
REQ-014 SHALL have port busy  output  1  high when any direction FIFO is non-empty.

Function
REQ-015 Source s SHALL be eligible when v_src_vld[s]=1 and either cmd_opcode != `CMD_WRITE, or the FIFO at cmd_txnid.direction_id is not full (registered count < DEPTH).
REQ-016 At most one source SHALL be granted per cycle, chosen round-robin among eligible sources, starting from pointer rr_ptr.
REQ-017 v_src_rdy SHALL be one-hot or zero and SHALL be combinational from v_src_vld, v_src_pld, FIFO counts and rr_ptr only, never from v_src_rdy or v_wresp_rdy.
REQ-018 On a grant to source g, rr_ptr SHALL become (g+1) mod NSRC the next cycle; with no grant, rr_ptr SHALL hold.
REQ-019 A granted write SHALL push {txnid=cmd_txnid, sideband=cmd_sideband} into FIFO[direction_id].
REQ-020 A granted non-write SHALL be accepted and discarded, with no FIFO change.
REQ-021 A direction_id >= WIDTH SHALL be treated as a non-write: accepted and discarded.
REQ-022 Each FIFO SHALL be in-order with no bypass: an entry pushed at edge N is visible on v_wresp_vld/pld from cycle N+1.
REQ-023 v_wresp_vld[d] SHALL equal (count[d] != 0); v_wresp_pld[d] SHALL be the head entry, and it SHALL be stable while valid and not ready.
REQ-024 A pop SHALL occur when v_wresp_vld[d] and v_wresp_rdy[d] are both 1.
REQ-025 On a simultaneous push and pop on the same FIFO, count SHALL be unchanged and both operations SHALL take effect.
REQ-026 A full FIFO SHALL refuse a push even if it is popped in the same cycle; eligibility uses the registered count.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 A FIFO count SHALL never exceed DEPTH or underflow below 0.
REQ-029 A stalled direction SHALL NOT block writes to other directions, nor non-writes.
REQ-030 busy SHALL equal the OR over d of (count[d] != 0).

Reset
REQ-031 While rst_n=0, asynchronously: all counts and pointers 0, rr_ptr=0, v_wresp_vld=0, busy=0, v_fifo_cnt=0.
REQ-032 FIFO storage SHALL NOT be reset; v_wresp_pld content SHALL be don't-care while its valid is 0.
REQ-033 Assertion of reset mid-operation SHALL discard all queued responses; no response SHALL be emitted for them after release.
REQ-034 v_src_rdy SHALL be 0 while rst_n=0.

Verification
REQ-035 A single write from src0 with direction_id=2, txnid=0x16 and v_wresp_rdy=all 1 SHALL give v_wresp_vld=4'b0100 with txnid 0x16 one cycle after acceptance, then busy=0.
REQ-036 src0 and src1 both valid with writes to directions 0 and 1 every cycle SHALL give grants alternating src0, src1, src0, ... starting from src0 after reset.
REQ-037 With v_wresp_rdy[3]=0 and 5 writes to direction 3 (DEPTH=4): 4 SHALL be accepted, the 5th SHALL be held (v_src_rdy=0) and v_fifo_cnt[3]=4. Releasing ready SHALL drain the entries in order and then accept the 5th.
REQ-038 With direction 3 full, a concurrent write to direction 1 from the other source and a non-write opcode SHALL both be accepted. The non-write SHALL produce no response.
REQ-039 A FIFO at count 2 with a simultaneous push and pop SHALL stay at count 2. Eight or more total pushes SHALL show correct ordering across pointer wrap.
REQ-040 Asserting rst_n=0 with 3 entries queued SHALL clear all v_wresp_vld to 0 immediately. After release, no stale response SHALL appear.
